riscv_dmem_responder: RTL and testbench

//  Memory-side responder for the core's data load/store port. Accepts one request at a time over a

---
 rtl/riscv_dmem_responder_pkg.sv | 18 +
 rtl/riscv_dmem_responder_if.sv | 24 ++
 rtl/riscv_dmem_responder_lsu_align.sv | 46 ++++
 rtl/riscv_dmem_responder.sv | 125 ++++++++++++
 tb/tb_riscv_dmem_responder.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/riscv_dmem_responder_pkg.sv
// Shared types for the data-memory responder: access size encoding and FSM states.
package riscv_dmem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } MEM_SIZE;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_WAIT = 2'b01,
        DMEM_RESP = 2'b10
    } DMEM_STATE;

    localparam int DMEM_CNT_W = 4;

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// Load/store request and response handshake between the core (master) and the responder (slave).
interface riscv_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/riscv_dmem_responder_lsu_align.sv
// Combinational byte/half/word lane steering for stores and extension for loads.
// An illegal size (2'b11) is reported through misaligned_o so one flag covers every format fault.
module riscv_lsu_align
    import riscv_dmem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_lane_o,
    output logic [31:0] rdata_ext_o,
    output logic        misaligned_o
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte        = rword_i[{addr_lo_i, 3'b000} +: 8];
        rhalf        = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        byte_en_o    = 4'b0000;
        wdata_lane_o = wdata_i;
        rdata_ext_o  = 32'd0;
        misaligned_o = 1'b0;
        case (size_i)
            MEM_B: begin
                byte_en_o    = 4'b0001 << addr_lo_i;
                wdata_lane_o = {4{wdata_i[7:0]}};
                rdata_ext_o  = {{24{~unsigned_i & rbyte[7]}}, rbyte};
            end
            MEM_H: begin
                byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_lane_o = {2{wdata_i[15:0]}};
                rdata_ext_o  = {{16{~unsigned_i & rhalf[15]}}, rhalf};
                misaligned_o = addr_lo_i[0];
            end
            MEM_W: begin
                byte_en_o    = 4'b1111;
                rdata_ext_o  = rword_i;
                misaligned_o = |addr_lo_i;
            end
            default: misaligned_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, registered response.
// Stores commit on the acceptance edge; loads read the array on the edge that enters RESP.
module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   x_reset,
    riscv_dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] CNT_LAST = DMEM_CNT_W'(WAIT_CYCLES);

    DMEM_STATE             state_q;
    logic [DMEM_CNT_W-1:0] cnt_q;
    logic [1:0]            addr_lo_q;
    logic [AW-1:0]         idx_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic                  we_q;
    logic                  err_q;
    logic [31:0]           rdata_q;
    logic                  resp_err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          idle;
    logic          accept;
    logic          in_range;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic [1:0]    al_addr;
    logic [1:0]    al_size;
    logic          al_unsigned;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lane;
    logic [31:0]   rdata_ext;
    logic          misaligned;

    assign idle     = (state_q == DMEM_IDLE);
    assign accept   = idle && bus.req_valid;
    assign in_range = ({2'b00, bus.req_addr[31:2]} < 32'(DEPTH_WORDS));
    assign req_idx  = bus.req_addr[2 +: AW];
    assign req_err  = misaligned || !in_range;

    // The aligner sees the live request in IDLE (store path) and the latched one afterwards (load path).
    assign al_addr     = idle ? bus.req_addr[1:0]  : addr_lo_q;
    assign al_size     = idle ? bus.req_size       : size_q;
    assign al_unsigned = idle ? bus.req_unsigned   : unsigned_q;

    riscv_lsu_align u_align (
        .addr_lo_i    (al_addr),
        .size_i       (al_size),
        .unsigned_i   (al_unsigned),
        .wdata_i      (bus.req_wdata),
        .rword_i      (mem_q[idx_q]),
        .byte_en_o    (byte_en),
        .wdata_lane_o (wdata_lane),
        .rdata_ext_o  (rdata_ext),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[req_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    // The counter runs 0..WAIT_CYCLES, so RESP is entered WAIT_CYCLES+1 edges after acceptance.
    always_ff @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            state_q    <= DMEM_IDLE;
            cnt_q      <= '0;
            addr_lo_q  <= 2'b00;
            idx_q      <= '0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            resp_err_q <= 1'b0;
        end else begin
            case (state_q)
                DMEM_IDLE: begin
                    if (accept) begin
                        addr_lo_q  <= bus.req_addr[1:0];
                        idx_q      <= req_idx;
                        size_q     <= bus.req_size;
                        unsigned_q <= bus.req_unsigned;
                        we_q       <= bus.req_we;
                        err_q      <= req_err;
                        cnt_q      <= '0;
                        state_q    <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        rdata_q    <= (we_q || err_q) ? 32'd0 : rdata_ext;
                        resp_err_q <= err_q;
                        state_q    <= DMEM_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DMEM_RESP: begin
                    if (bus.resp_ready) begin
                        rdata_q    <= 32'd0;
                        resp_err_q <= 1'b0;
                        state_q    <= DMEM_IDLE;
                    end
                end
                default: state_q <= DMEM_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = idle;
    assign bus.resp_valid = (state_q == DMEM_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench: a WAIT_CYCLES=2 responder and a WAIT_CYCLES=0 responder share one request stream.
module tb_riscv_dmem_responder;
    localparam int W0    = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic x_reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    riscv_dmem_responder_if bus0 ();
    riscv_dmem_responder_if bus1 ();

    assign bus1.req_valid    = bus0.req_valid;
    assign bus1.req_addr     = bus0.req_addr;
    assign bus1.req_we       = bus0.req_we;
    assign bus1.req_size     = bus0.req_size;
    assign bus1.req_unsigned = bus0.req_unsigned;
    assign bus1.req_wdata    = bus0.req_wdata;
    assign bus1.resp_ready   = bus0.resp_ready;

    riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .x_reset(x_reset), .bus(bus0));
    riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .x_reset(x_reset), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int lat0;
        int lat1;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(bus0.req_ready), 32'd1);
        bus0.req_valid    = 1'b1;
        bus0.req_we       = we;
        bus0.req_addr     = addr;
        bus0.req_size     = size;
        bus0.req_unsigned = uns;
        bus0.req_wdata    = wdata;
        @(posedge clk);
        #1;
        // Garbage on the request lines after acceptance must be ignored.
        bus0.req_valid    = 1'b0;
        bus0.req_we       = ~we;
        bus0.req_addr     = 32'hFFFF_FFFF;
        bus0.req_size     = 2'b11;
        bus0.req_unsigned = ~uns;
        bus0.req_wdata    = 32'h5A5A_5A5A;
        lat0 = -1;
        lat1 = -1;
        for (int c = 1; c <= 40 && lat0 < 0; c++) begin
            @(posedge clk);
            #1;
            if (bus1.resp_valid && lat1 < 0) lat1 = c;
            if (bus0.resp_valid) lat0 = c;
        end
        chk({tag, ".lat_w2"}, 32'(lat0), 32'(1 + W0));
        chk({tag, ".lat_w0"}, 32'(lat1), 32'd1);
        chk({tag, ".rdata"}, bus0.resp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(bus0.resp_err), 32'(exp_err));
        chk({tag, ".rdata_w0"}, bus1.resp_rdata, exp_rdata);
        chk({tag, ".err_w0"}, 32'(bus1.resp_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 32'(bus0.resp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, bus0.resp_rdata, exp_rdata);
            chk({tag, ".hold_ready"}, 32'(bus0.req_ready), 32'd0);
        end
        @(negedge clk);
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.resp_ready = 1'b0;
        chk({tag, ".idle_ready"}, 32'(bus0.req_ready), 32'd1);
        chk({tag, ".idle_valid"}, 32'(bus0.resp_valid), 32'd0);
    endtask

    initial begin
        bus0.req_valid    = 1'b0;
        bus0.req_we       = 1'b0;
        bus0.req_addr     = 32'd0;
        bus0.req_size     = 2'b00;
        bus0.req_unsigned = 1'b0;
        bus0.req_wdata    = 32'd0;
        bus0.resp_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(bus0.req_ready), 32'd1);
        chk("rst.resp_valid", 32'(bus0.resp_valid), 32'd0);
        chk("rst.rdata", bus0.resp_rdata, 32'd0);
        chk("rst.err", 32'(bus0.resp_err), 32'd0);
        chk("rst.resp_valid_w0", 32'(bus1.resp_valid), 32'd0);
        @(negedge clk);
        x_reset = 1'b0;

        // Word store then load
        req("st_w",   1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b0, 0);
        req("ld_w",   1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
        // Extension on byte/half loads
        req("st_w2",  1'b1, 32'h10, 2'b10, 1'b0, 32'h80FF_7F01, 32'h0,         1'b0, 0);
        req("ld_bs",  1'b0, 32'h13, 2'b00, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0, 0);
        req("ld_bu",  1'b0, 32'h13, 2'b00, 1'b1, 32'h0,         32'h0000_0080, 1'b0, 0);
        req("ld_hs",  1'b0, 32'h12, 2'b01, 1'b0, 32'h0,         32'hFFFF_80FF, 1'b0, 0);
        req("ld_hu",  1'b0, 32'h10, 2'b01, 1'b1, 32'h0,         32'h0000_7F01, 1'b0, 0);
        req("ld_b1",  1'b0, 32'h11, 2'b00, 1'b0, 32'h0,         32'h0000_007F, 1'b0, 0);
        // Byte/half store lane steering
        req("st_w0",  1'b1, 32'h10, 2'b10, 1'b0, 32'h0,         32'h0,         1'b0, 0);
        req("st_b",   1'b1, 32'h11, 2'b00, 1'b0, 32'h1234_56AA, 32'h0,         1'b0, 0);
        req("ld_wb",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         32'h0000_AA00, 1'b0, 0);
        req("st_h",   1'b1, 32'h12, 2'b01, 1'b0, 32'hFFFF_BEEF, 32'h0,         1'b0, 0);
        req("ld_wh",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0,         32'hBEEF_AA00, 1'b0, 0);
        // Error cases leave the array untouched
        req("st_w00", 1'b1, 32'h0,    2'b10, 1'b0, 32'h1122_3344, 32'h0,       1'b0, 0);
        req("ld_misw",1'b0, 32'h0A,   2'b10, 1'b0, 32'h0,         32'h0,       1'b1, 0);
        req("st_mish",1'b1, 32'h03,   2'b01, 1'b0, 32'hFFFF_BEEF, 32'h0,       1'b1, 0);
        req("st_oor", 1'b1, 32'h1000, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0,       1'b1, 0);
        req("ld_oor", 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0,         32'h0,       1'b1, 0);
        req("st_bad", 1'b1, 32'h0,    2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0,       1'b1, 0);
        req("ld_keep",1'b0, 32'h0,    2'b10, 1'b0, 32'h0,         32'h1122_3344, 1'b0, 0);
        // Consumer stalls for five cycles
        req("ld_hold",1'b0, 32'h0,    2'b10, 1'b0, 32'h0,         32'h1122_3344, 1'b0, 5);

        // Reset during WAIT after an accepted store
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 32'h20;
        bus0.req_size  = 2'b10;
        bus0.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        @(negedge clk);
        chk("abort.pre_valid", 32'(bus0.resp_valid), 32'd0);
        chk("abort.pre_ready", 32'(bus0.req_ready), 32'd0);
        x_reset = 1'b1;
        #1;
        chk("abort.resp_valid", 32'(bus0.resp_valid), 32'd0);
        chk("abort.req_ready", 32'(bus0.req_ready), 32'd1);
        chk("abort.rdata", bus0.resp_rdata, 32'd0);
        @(negedge clk);
        x_reset = 1'b0;
        req("ld_abort", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
